// File: rtl/mn_matrix_pkg.sv
// Shared constants, command encodings and FSM state encoding
// for the mn_matrix sequencer and its read-return FIFO.
package mn_matrix_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int MAX_DIM = 128;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DUMP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mn_matrix_seq_if.sv
// Command, load-stream and dump-stream bundle of mn_matrix_seq.
// master: the data mover driving commands; slave: the sequencer.
interface mn_matrix_seq_if;
    import mn_matrix_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic              cmd_transpose;
    logic [ADDR_W-1:0] cmd_m;
    logic [ADDR_W-1:0] cmd_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_transpose, cmd_m, cmd_n,
        output in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_transpose, cmd_m, cmd_n,
        input  in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, done, err
    );

endinterface

// File: rtl/mn_rd_fifo.sv
// Synchronous FIFO for store read returns.
// Ports: clk, reset, i_push/i_data, i_pop, o_data (head), o_empty, o_count.
module mn_rd_fifo #(
    parameter int W = 32,
    parameter int D = 4,
    localparam int AW = (D > 1) ? $clog2(D) : 1,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] f_nxt(input logic [AW-1:0] p);
        return (p == AW'(D - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_full  = (r_cnt == CW'(D));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rp];
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < D; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= f_nxt(r_wp);
            end
            if (w_pop) r_rp <= f_nxt(r_rp);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mn_matrix_seq.sv
// Sequencer owning one mn_matrix store: LOAD streams row-major data in,
// DUMP streams it out (optionally transposed) with full backpressure.
// Ports: clk, reset, bus (cmd/in/out streams, done, err), mat_* store pins.
module mn_matrix_seq
    import mn_matrix_pkg::*;
#(
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              reset,
    mn_matrix_seq_if.slave    bus,
    output logic              mat_write,
    output logic              mat_read,
    output logic              mat_transpose,
    output logic [ADDR_W-1:0] mat_m_dim,
    output logic [ADDR_W-1:0] mat_n_dim,
    output logic [ADDR_W-1:0] mat_m_addr,
    output logic [ADDR_W-1:0] mat_n_addr,
    output logic [DATA_W-1:0] mat_data_in,
    input  logic [DATA_W-1:0] mat_data_out
);

    localparam int CW = $clog2(FIFO_D + 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_m;
    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_r;
    logic [ADDR_W-1:0] r_c;
    logic              r_tr;
    logic              r_pend;
    logic              r_err;
    logic              w_fire;
    logic              w_bad;
    logic              w_wr;
    logic              w_rd;
    logic              w_pop;
    logic              w_empty;
    logic              w_last_c;
    logic              w_last;
    logic              w_drained;
    logic [ADDR_W-1:0] w_rows;
    logic [ADDR_W-1:0] w_cols;
    logic [CW-1:0]     w_cnt;
    logic [CW:0]       w_used;
    logic [DATA_W-1:0] w_head;

    assign w_fire = bus.cmd_valid && (r_state == ST_IDLE) && !reset;
    assign w_bad  = (bus.cmd_m == '0) || (bus.cmd_m > ADDR_W'(MAX_DIM))
                 || (bus.cmd_n == '0) || (bus.cmd_n > ADDR_W'(MAX_DIM));

    // A transposed dump walks the n x m view of the store.
    assign w_rows   = r_tr ? r_n : r_m;
    assign w_cols   = r_tr ? r_m : r_n;
    assign w_last_c = (r_c == w_cols - ADDR_W'(1));
    assign w_last   = w_last_c && (r_r == w_rows - ADDR_W'(1));

    // Credit: a read is only issued if its return is sure to find a slot.
    assign w_used = {1'b0, w_cnt} + {{CW{1'b0}}, r_pend};
    assign w_wr   = (r_state == ST_LOAD) && bus.in_valid;
    assign w_rd   = (r_state == ST_DUMP) && (w_used < (CW + 1)'(FIFO_D));
    assign w_pop  = !w_empty && bus.out_ready;

    // Finishing on the last pop itself puts done right after the handshake.
    assign w_drained = !r_pend
                    && ((w_cnt == '0) || ((w_cnt == CW'(1)) && w_pop));

    mn_rd_fifo #(
        .W (DATA_W),
        .D (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_pend),
        .i_data  (mat_data_out),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fire && !w_bad)
                    w_next = (bus.cmd_op == OP_LOAD) ? ST_LOAD : ST_DUMP;
            end
            ST_LOAD:  if (w_wr && w_last) w_next = ST_DONE;
            ST_DUMP:  if (w_rd && w_last) w_next = ST_DRAIN;
            ST_DRAIN: if (w_drained) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == ST_IDLE) && !reset;
        bus.in_ready  = (r_state == ST_LOAD);
        bus.done      = (r_state == ST_DONE);
        bus.err       = r_err;
        bus.out_valid = !w_empty;
        bus.out_data  = w_head;
        mat_write     = w_wr;
        mat_read      = w_rd;
        mat_transpose = (r_state == ST_DUMP) && r_tr;
        mat_data_in   = (r_state == ST_LOAD) ? bus.in_data : '0;
        mat_m_dim     = r_m;
        mat_n_dim     = r_n;
        mat_m_addr    = r_r;
        mat_n_addr    = r_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m    <= '0;
            r_n    <= '0;
            r_r    <= '0;
            r_c    <= '0;
            r_tr   <= 1'b0;
            r_pend <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= w_rd;
            r_err  <= w_fire && w_bad;
            if (w_fire && !w_bad) begin
                r_m  <= bus.cmd_m;
                r_n  <= bus.cmd_n;
                r_tr <= (bus.cmd_op == OP_DUMP) && bus.cmd_transpose;
                r_r  <= '0;
                r_c  <= '0;
            end else if (w_wr || w_rd) begin
                if (w_last_c) begin
                    r_c <= '0;
                    r_r <= r_r + ADDR_W'(1);
                end else begin
                    r_c <= r_c + ADDR_W'(1);
                end
            end
        end
    end

endmodule
